// File: rtl/writeback_stage_if.sv
// ============================================================================
// Module   : writeback_stage_if
// Brief    : Bundles the MEM-stage, M-unit and register-file write signals
//            of the writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface writeback_stage_if;
  logic        mem_valid;
  logic        mem_wb_reg_file;
  logic        mem_wb_load;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_addr_lsb;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_read_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_result;
  logic        md_ready;
  logic        wb_stall;
  logic        reg_file_wr_en;
  logic [4:0]  reg_file_wr_addr;
  logic [31:0] reg_file_wr_data;

  modport master (
    output mem_valid, mem_wb_reg_file, mem_wb_load, mem_load_type, mem_addr_lsb,
           mem_rd, mem_alu_result, mem_read_data, md_valid, md_rd, md_result,
    input  md_ready, wb_stall, reg_file_wr_en, reg_file_wr_addr, reg_file_wr_data
  );

  modport slave (
    input  mem_valid, mem_wb_reg_file, mem_wb_load, mem_load_type, mem_addr_lsb,
           mem_rd, mem_alu_result, mem_read_data, md_valid, md_rd, md_result,
    output md_ready, wb_stall, reg_file_wr_en, reg_file_wr_addr, reg_file_wr_data
  );
endinterface

`default_nettype wire

// File: rtl/writeback_stage.sv
// ============================================================================
// Module   : writeback_stage
// Brief    : Arbitrates the single register-file write port between the
//            retiring MEM-stage instruction and the multiply/divide unit,
//            with load alignment and starvation protection for the M unit.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module writeback_stage #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  writeback_stage_if.slave  wb
);

  localparam logic [2:0] c_starve_limit = 3'(STARVE_LIMIT);

  logic [2:0]  r_starve_cnt;
  logic        w_pipe_req;
  logic        w_md_req;
  logic        w_force_md;
  logic        w_grant_md;
  logic        w_grant_pipe;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_pipe_data;

  assign w_pipe_req = wb.mem_valid & wb.mem_wb_reg_file;
  assign w_md_req   = wb.md_valid;
  assign w_force_md = (r_starve_cnt == c_starve_limit);

  // Grants are masked during reset so the combinational handshakes read 0.
  assign w_grant_md   = ~rst & w_md_req & (w_force_md | ~w_pipe_req);
  assign w_grant_pipe = ~rst & w_pipe_req & ~w_grant_md;

  assign wb.md_ready = w_grant_md;
  assign wb.wb_stall = w_grant_md & w_pipe_req;

  always_comb begin
    w_byte = 8'h00;
    case (wb.mem_addr_lsb)
      2'd0:    w_byte = wb.mem_read_data[7:0];
      2'd1:    w_byte = wb.mem_read_data[15:8];
      2'd2:    w_byte = wb.mem_read_data[23:16];
      default: w_byte = wb.mem_read_data[31:24];
    endcase
    w_half = wb.mem_addr_lsb[1] ? wb.mem_read_data[31:16] : wb.mem_read_data[15:0];

    w_load_data = 32'h0;
    case (wb.mem_load_type)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b010:  w_load_data = wb.mem_read_data;
      3'b100:  w_load_data = {24'h0, w_byte};
      3'b101:  w_load_data = {16'h0, w_half};
      default: w_load_data = 32'h0;
    endcase

    w_pipe_data = wb.mem_wb_load ? w_load_data : wb.mem_alu_result;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt        <= 3'd0;
      wb.reg_file_wr_en   <= 1'b0;
      wb.reg_file_wr_addr <= 5'd0;
      wb.reg_file_wr_data <= 32'h0;
    end else begin
      // Saturating wait counter; any acceptance or idle cycle restarts it.
      if (w_md_req && !w_grant_md) begin
        if (r_starve_cnt != c_starve_limit) begin
          r_starve_cnt <= r_starve_cnt + 3'd1;
        end
      end else begin
        r_starve_cnt <= 3'd0;
      end

      if (w_grant_md) begin
        wb.reg_file_wr_en   <= (wb.md_rd != 5'd0);
        wb.reg_file_wr_addr <= wb.md_rd;
        wb.reg_file_wr_data <= wb.md_result;
      end else if (w_grant_pipe) begin
        wb.reg_file_wr_en   <= (wb.mem_rd != 5'd0);
        wb.reg_file_wr_addr <= wb.mem_rd;
        wb.reg_file_wr_data <= w_pipe_data;
      end else begin
        wb.reg_file_wr_en   <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ============================================================================
// Module   : tb_writeback_stage
// Brief    : Directed self-checking bench for writeback_stage.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_writeback_stage;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  writeback_stage_if wbif ();

  writeback_stage #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wbif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  lt;
    logic [1:0]  lsb;
    logic [31:0] rdata;
    logic [31:0] exp;
  } load_vec_t;

  load_vec_t lv [10];

  task automatic mem_in(input logic v, input logic wrf, input logic ld,
                        input logic [2:0] lt, input logic [1:0] lsb, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] rdata);
    wbif.mem_valid       = v;
    wbif.mem_wb_reg_file = wrf;
    wbif.mem_wb_load     = ld;
    wbif.mem_load_type   = lt;
    wbif.mem_addr_lsb    = lsb;
    wbif.mem_rd          = rd;
    wbif.mem_alu_result  = alu;
    wbif.mem_read_data   = rdata;
  endtask

  task automatic md_in(input logic v, input logic [4:0] rd, input logic [31:0] res);
    wbif.md_valid  = v;
    wbif.md_rd     = rd;
    wbif.md_result = res;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mem_in(1'b1, 1'b1, 1'b0, 3'b000, 2'd0, 5'd4, 32'h1111_1111, 32'h0);
    md_in(1'b1, 5'd6, 32'h2222_2222);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (wbif.reg_file_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wbif.reg_file_wr_en); end
    n_checks++; if (wbif.reg_file_wr_addr !== 5'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d want 0", wbif.reg_file_wr_addr); end
    n_checks++; if (wbif.reg_file_wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", wbif.reg_file_wr_data); end
    n_checks++; if (wbif.md_ready !== 1'b0) begin n_fail++; $display("FAIL reset_md_ready: got %b want 0", wbif.md_ready); end
    n_checks++; if (wbif.wb_stall !== 1'b0) begin n_fail++; $display("FAIL reset_wb_stall: got %b want 0", wbif.wb_stall); end
    mem_in(1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 5'd0, 32'h0, 32'h0);
    md_in(1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_paths;
    lv = '{
      '{3'b000, 2'd2, 32'h0080_0000, 32'hFFFF_FF80},
      '{3'b100, 2'd2, 32'h0080_0000, 32'h0000_0080},
      '{3'b000, 2'd0, 32'h1234_567F, 32'h0000_007F},
      '{3'b100, 2'd3, 32'hA500_0000, 32'h0000_00A5},
      '{3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001},
      '{3'b001, 2'd1, 32'h0000_F00D, 32'hFFFF_F00D},
      '{3'b101, 2'd3, 32'hBEEF_0000, 32'h0000_BEEF},
      '{3'b010, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF},
      '{3'b011, 2'd0, 32'hFFFF_FFFF, 32'h0000_0000},
      '{3'b111, 2'd2, 32'h8080_8080, 32'h0000_0000}
    };
    md_in(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      mem_in(1'b1, 1'b1, 1'b1, lv[i].lt, lv[i].lsb, 5'(5 + i), 32'h5A5A_5A5A, lv[i].rdata);
      #1;
      n_checks++; if (wbif.wb_stall !== 1'b0) begin n_fail++; $display("FAIL load%0d_wb_stall: got %b want 0", i, wbif.wb_stall); end
      tick();
      n_checks++; if (wbif.reg_file_wr_en !== 1'b1) begin n_fail++; $display("FAIL load%0d_wr_en: got %b want 1", i, wbif.reg_file_wr_en); end
      n_checks++; if (wbif.reg_file_wr_addr !== 5'(5 + i)) begin n_fail++; $display("FAIL load%0d_wr_addr: got %0d want %0d", i, wbif.reg_file_wr_addr, 5 + i); end
      n_checks++; if (wbif.reg_file_wr_data !== lv[i].exp) begin n_fail++; $display("FAIL load%0d_wr_data: got %h want %h", i, wbif.reg_file_wr_data, lv[i].exp); end
    end
  endtask

  task automatic test_alu_and_idle;
    // Load type and lsb must be ignored when the write is not a load.
    mem_in(1'b1, 1'b1, 1'b0, 3'b000, 2'd2, 5'd20, 32'h1357_2468, 32'hFFFF_FFFF);
    tick();
    n_checks++; if (wbif.reg_file_wr_data !== 32'h1357_2468) begin n_fail++; $display("FAIL alu_wr_data: got %h want 13572468", wbif.reg_file_wr_data); end
    n_checks++; if (wbif.reg_file_wr_addr !== 5'd20) begin n_fail++; $display("FAIL alu_wr_addr: got %0d want 20", wbif.reg_file_wr_addr); end
    mem_in(1'b0, 1'b1, 1'b0, 3'b000, 2'd0, 5'd21, 32'h9999_9999, 32'h0);
    tick();
    n_checks++; if (wbif.reg_file_wr_en !== 1'b0) begin n_fail++; $display("FAIL idle_wr_en: got %b want 0", wbif.reg_file_wr_en); end
    n_checks++; if (wbif.reg_file_wr_addr !== 5'd20) begin n_fail++; $display("FAIL idle_wr_addr_hold: got %0d want 20", wbif.reg_file_wr_addr); end
    n_checks++; if (wbif.reg_file_wr_data !== 32'h1357_2468) begin n_fail++; $display("FAIL idle_wr_data_hold: got %h want 13572468", wbif.reg_file_wr_data); end
  endtask

  task automatic test_starvation;
    logic exp_grant;
    md_in(1'b1, 5'd7, 32'h0000_1234);
    for (int k = 1; k <= 5; k++) begin
      mem_in(1'b1, 1'b1, 1'b0, 3'b000, 2'd0, 5'd10, 32'h100 + 32'(k), 32'h0);
      #1;
      exp_grant = (k == 5);
      n_checks++; if (wbif.md_ready !== exp_grant) begin n_fail++; $display("FAIL starve_c%0d_md_ready: got %b want %b", k, wbif.md_ready, exp_grant); end
      n_checks++; if (wbif.wb_stall !== exp_grant) begin n_fail++; $display("FAIL starve_c%0d_wb_stall: got %b want %b", k, wbif.wb_stall, exp_grant); end
      tick();
      if (k < 5) begin
        n_checks++; if (wbif.reg_file_wr_data !== 32'h100 + 32'(k)) begin n_fail++; $display("FAIL starve_c%0d_pipe_data: got %h want %h", k, wbif.reg_file_wr_data, 32'h100 + 32'(k)); end
      end else begin
        n_checks++; if (wbif.reg_file_wr_addr !== 5'd7) begin n_fail++; $display("FAIL starve_md_addr: got %0d want 7", wbif.reg_file_wr_addr); end
        n_checks++; if (wbif.reg_file_wr_data !== 32'h0000_1234) begin n_fail++; $display("FAIL starve_md_data: got %h want 00001234", wbif.reg_file_wr_data); end
      end
    end
    // The stalled instruction is re-presented unchanged and must now retire.
    md_in(1'b0, 5'd0, 32'h0);
    #1;
    n_checks++; if (wbif.wb_stall !== 1'b0) begin n_fail++; $display("FAIL replay_wb_stall: got %b want 0", wbif.wb_stall); end
    tick();
    n_checks++; if (wbif.reg_file_wr_en !== 1'b1) begin n_fail++; $display("FAIL replay_wr_en: got %b want 1", wbif.reg_file_wr_en); end
    n_checks++; if (wbif.reg_file_wr_addr !== 5'd10) begin n_fail++; $display("FAIL replay_wr_addr: got %0d want 10", wbif.reg_file_wr_addr); end
    n_checks++; if (wbif.reg_file_wr_data !== 32'h0000_0105) begin n_fail++; $display("FAIL replay_wr_data: got %h want 00000105", wbif.reg_file_wr_data); end
  endtask

  task automatic test_x0_and_store;
    mem_in(1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 5'd0, 32'h0, 32'h0);
    md_in(1'b1, 5'd0, 32'hDEAD_0000);
    #1;
    n_checks++; if (wbif.md_ready !== 1'b1) begin n_fail++; $display("FAIL x0_md_ready: got %b want 1", wbif.md_ready); end
    tick();
    n_checks++; if (wbif.reg_file_wr_en !== 1'b0) begin n_fail++; $display("FAIL x0_wr_en: got %b want 0", wbif.reg_file_wr_en); end
    mem_in(1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 5'd12, 32'h0000_0055, 32'h0);
    md_in(1'b1, 5'd3, 32'h0000_CAFE);
    #1;
    n_checks++; if (wbif.md_ready !== 1'b1) begin n_fail++; $display("FAIL store_md_ready: got %b want 1", wbif.md_ready); end
    n_checks++; if (wbif.wb_stall !== 1'b0) begin n_fail++; $display("FAIL store_wb_stall: got %b want 0", wbif.wb_stall); end
    tick();
    n_checks++; if (wbif.reg_file_wr_en !== 1'b1) begin n_fail++; $display("FAIL store_wr_en: got %b want 1", wbif.reg_file_wr_en); end
    n_checks++; if (wbif.reg_file_wr_addr !== 5'd3) begin n_fail++; $display("FAIL store_wr_addr: got %0d want 3", wbif.reg_file_wr_addr); end
    n_checks++; if (wbif.reg_file_wr_data !== 32'h0000_CAFE) begin n_fail++; $display("FAIL store_wr_data: got %h want 0000cafe", wbif.reg_file_wr_data); end
  endtask

  task automatic test_reset_mid;
    logic exp_grant;
    md_in(1'b1, 5'd7, 32'h0000_0077);
    mem_in(1'b1, 1'b1, 1'b0, 3'b000, 2'd0, 5'd11, 32'h0000_0200, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      #1;
      n_checks++; if (wbif.md_ready !== 1'b0) begin n_fail++; $display("FAIL pre_rst_c%0d_md_ready: got %b want 0", k, wbif.md_ready); end
      tick();
    end
    rst = 1'b1;
    #1;
    n_checks++; if (wbif.reg_file_wr_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wr_en: got %b want 0", wbif.reg_file_wr_en); end
    n_checks++; if (wbif.reg_file_wr_addr !== 5'd0) begin n_fail++; $display("FAIL mid_rst_wr_addr: got %0d want 0", wbif.reg_file_wr_addr); end
    n_checks++; if (wbif.reg_file_wr_data !== 32'h0) begin n_fail++; $display("FAIL mid_rst_wr_data: got %h want 0", wbif.reg_file_wr_data); end
    n_checks++; if (wbif.md_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_md_ready: got %b want 0", wbif.md_ready); end
    n_checks++; if (wbif.wb_stall !== 1'b0) begin n_fail++; $display("FAIL mid_rst_wb_stall: got %b want 0", wbif.wb_stall); end
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      exp_grant = (k == 5);
      n_checks++; if (wbif.md_ready !== exp_grant) begin n_fail++; $display("FAIL post_rst_c%0d_md_ready: got %b want %b", k, wbif.md_ready, exp_grant); end
      tick();
    end
    n_checks++; if (wbif.reg_file_wr_data !== 32'h0000_0077) begin n_fail++; $display("FAIL post_rst_md_data: got %h want 00000077", wbif.reg_file_wr_data); end
    md_in(1'b0, 5'd0, 32'h0);
    mem_in(1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 5'd0, 32'h0, 32'h0);
    tick();
  endtask

  initial begin
    test_reset();
    test_load_paths();
    test_alu_and_idle();
    test_starvation();
    test_x0_and_store();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
